// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single port of the 16-bit data memory between two requesters:
//   port 0 : CPU load/store stage
//   port 1 : DMA / program loader
// Each transaction takes three cycles: IDLE (arbitrate and latch the command),
// ACCESS (drive the memory), DONE (one-cycle ack to the winner).
//
// Build option:
//   DATA_MEM_ARB_RR_EN  defined   -> round-robin tie-break (port not granted last)
//                       undefined -> fixed priority, port 0 over port 1
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pN_req / pN_we                request (held until ack) and write enable
//   pN_addr / pN_wdata            byte address and write data
//   pN_ack                        one-cycle completion pulse
//   pN_rdata                      registered read data, held after ack
//   mem_access_addr/_write_data   command to the memory (zero outside ACCESS)
//   mem_write_en / mem_read       memory strobes (zero outside ACCESS)
//   mem_read_data                 combinational read data from the memory
//   busy                          high in ACCESS and DONE
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              winner_q;       // 0 = port 0, 1 = port 1
  logic              last_grant_q;   // port served by the previous transaction
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;

  logic any_req;
  logic rr_pick;
  logic grant;

  // Arbitration: a lone requester always wins; a tie goes either to the port
  // not served last (round-robin) or to port 0 (fixed priority).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    any_req = p0_req | p1_req;
    rr_pick = ~last_grant_q;
    grant   = p1_req;
    if (p0_req && p1_req) begin
      grant = RR_EN ? rr_pick : 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Command latch, read-data capture and last-grant bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is small and reset explicitly, including the
    // read-data holding registers, so outputs are defined straight out of reset.
    if (!rst_n) begin
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            winner_q    <= grant;
            lat_we_q    <= grant ? p1_we    : p0_we;
            lat_addr_q  <= grant ? p1_addr  : p0_addr;
            lat_wdata_q <= grant ? p1_wdata : p0_wdata;
          end
        end
        S_ACCESS: begin
          // Memory read is combinational; capture on the edge ending ACCESS.
          if (!lat_we_q) begin
            if (winner_q) p1_rdata <= mem_read_data;
            else          p0_rdata <= mem_read_data;
          end
        end
        S_DONE:  last_grant_q <= winner_q;
        default: ;
      endcase
    end
  end

  // Memory strobes are gated by the state register alone, so an asynchronous
  // reset during ACCESS removes the write enable immediately.
  always_comb begin
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    if (state_q == S_ACCESS) begin
      mem_write_en    = lat_we_q;
      mem_read        = ~lat_we_q;
      mem_access_addr = lat_addr_q;
      mem_write_data  = lat_wdata_q;
    end
  end

  assign p0_ack = (state_q == S_DONE) && !winner_q;
  assign p1_ack = (state_q == S_DONE) &&  winner_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. A behavioural 256-word memory is
// attached to the memory port. A transaction-level model (word-indexed memory,
// per-port read-data, last-grant) predicts winners, latencies and data.
// Follows DATA_MEM_ARB_RR_EN to choose the expected tie-break rule.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_ack;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_ack;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic          mem_read;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .p0_req          (p0_req),
    .p0_we           (p0_we),
    .p0_addr         (p0_addr),
    .p0_wdata        (p0_wdata),
    .p0_ack          (p0_ack),
    .p0_rdata        (p0_rdata),
    .p1_req          (p1_req),
    .p1_we           (p1_we),
    .p1_addr         (p1_addr),
    .p1_wdata        (p1_wdata),
    .p1_ack          (p1_ack),
    .p1_rdata        (p1_rdata),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .busy            (busy)
  );

  // Behavioural data memory: word index from address bits [8:1].
  logic [DW-1:0] env_mem [256] = '{default: '0};
  always @(posedge clk) if (mem_write_en) env_mem[mem_access_addr[8:1]] <= mem_write_data;
  assign mem_read_data = env_mem[mem_access_addr[8:1]];

  // Transaction-level reference model.
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] model_rdata [2];
  int            model_last;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
    int k = int'(addr[8:1]);
    return model_mem.exists(k) ? model_mem[k] : '0;
  endfunction

  task automatic model_apply(input int p, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    if (we) model_mem[int'(a[8:1])] = d;
    else    model_rdata[p] = model_read(a);
    model_last = p;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  // Waits (bounded) for the next ack; records the command seen on the memory
  // port, including the current cycle.
  task automatic wait_ack(output int port, output int n,
                          output logic [AW-1:0] a, output logic w);
    port = -1; n = 0; a = '0; w = 1'b0;
    if (mem_read || mem_write_en) begin a = mem_access_addr; w = mem_write_en; end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read || mem_write_en) begin a = mem_access_addr; w = mem_write_en; end
      if (p0_ack || p1_ack) begin
        port = p1_ack ? 1 : 0;
        n = i;
        break;
      end
    end
  endtask

  task automatic finish_txn(input string tag, input int exp_port, input int exp_n,
                            input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int got, n;
    logic [AW-1:0] seen_a;
    logic seen_w;
    wait_ack(got, n, seen_a, seen_w);
    check({tag, "_port"}, got, exp_port);
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_maddr"}, seen_a, a);
    check({tag, "_mwe"}, seen_w, we);
    check({tag, "_ack1hot"}, p0_ack & p1_ack, 0);
    model_apply(exp_port, we, a, d);
    check({tag, "_rd0"}, p0_rdata, model_rdata[0]);
    check({tag, "_rd1"}, p1_rdata, model_rdata[1]);
    drop_req(exp_port);
  endtask

  task automatic single(input string tag, input int p, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    set_port(p, 1'b1, we, a, d);
    finish_txn(tag, p, 2, we, a, d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {p0_ack, p1_ack, busy, mem_write_en, mem_read}, 0);
    check({tag, "_maddr"}, mem_access_addr, 0);
    check({tag, "_mwdata"}, mem_write_data, 0);
    check({tag, "_rdata"}, {p0_rdata, p1_rdata}, 0);
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks, releases at next negedge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    p0_req = 1'b0;
    p1_req = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    model_last = 1;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq [4];
    int pick, other, mask;
    logic          r_we [2];
    logic [AW-1:0] r_a  [2];
    logic [DW-1:0] r_d  [2];

    model_rdata[0] = '0;
    model_rdata[1] = '0;
    model_last = 1;

    // Reset state.
    #1 check_all_zero("rst0");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Preload through port 1.
    single("pre2", 1, 1'b1, 16'h0002, 16'h1111);
    single("pre4", 1, 1'b1, 16'h0004, 16'h2222);

    // Port 0 write then read, with cycle-level checks on the write.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    check("wr_acc_we", {mem_write_en, mem_read}, 2'b10);
    check("wr_acc_addr", mem_access_addr, 16'h0010);
    check("wr_acc_data", mem_write_data, 16'hBEEF);
    check("wr_acc_busy_ack", {busy, p0_ack}, 2'b10);
    finish_txn("wr", 0, 1, 1'b1, 16'h0010, 16'hBEEF);
    check("wr_done_we", mem_write_en, 0);
    @(negedge clk);
    check("wr_after", {p0_ack, busy, mem_write_en}, 0);
    check("wr_mem", env_mem[8], 16'hBEEF);
    single("rd10", 0, 1'b0, 16'h0010, 16'h0000);

    // Late request: p1 rises during p0's ACCESS, acked 3 cycles after p0.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    @(negedge clk);
    set_port(1, 1'b1, 1'b1, 16'h0030, 16'h5A5A);
    finish_txn("late_p0", 0, 1, 1'b0, 16'h0004, 16'h0000);
    finish_txn("late_p1", 1, 3, 1'b1, 16'h0030, 16'h5A5A);

    // Reset during ACCESS of a p1 write: no write, no ack.
    @(negedge clk);
    set_port(1, 1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    check("rstacc_we", mem_write_en, 1);
    do_reset("rstacc");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstacc_noack", {p0_ack, p1_ack}, 0);
    end
    single("rstacc_rd", 1, 1'b0, 16'h0020, 16'h0000);

    // Contention: both ports hold reads.
    for (int i = 0; i < 4; i++) exp_seq[i] = RR ? (i % 2) : 0;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    set_port(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k % 3 == 2) begin
        pick = exp_seq[(k - 2) / 3];
        check("cont_ack0", p0_ack, pick == 0);
        check("cont_ack1", p1_ack, pick == 1);
        model_apply(pick, 1'b0, pick ? 16'h0004 : 16'h0002, 16'h0000);
        check("cont_rd0", p0_rdata, model_rdata[0]);
        check("cont_rd1", p1_rdata, model_rdata[1]);
      end else begin
        check("cont_idle", {p0_ack, p1_ack}, 0);
      end
    end
    drop_req(exp_seq[3]);
    other = 1 - exp_seq[3];
    finish_txn("cont_last", other, 3, 1'b0, other ? 16'h0004 : 16'h0002, 16'h0000);

    // Randomized transactions against the model.
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        r_we[p] = 1'($urandom_range(0, 1));
        r_a[p]  = 16'($urandom) & 16'hFE1F;
        r_d[p]  = 16'($urandom);
        if (mask[p]) set_port(p, 1'b1, r_we[p], r_a[p], r_d[p]);
      end
      if (mask == 3) begin
        pick  = RR ? (1 - model_last) : 0;
        other = 1 - pick;
        finish_txn("rnd_a", pick, 2, r_we[pick], r_a[pick], r_d[pick]);
        finish_txn("rnd_b", other, 3, r_we[other], r_a[other], r_d[other]);
      end else begin
        pick = (mask == 2) ? 1 : 0;
        finish_txn("rnd_s", pick, 2, r_we[pick], r_a[pick], r_d[pick]);
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer for the 16-bit data memory `memoria_de_dados`. It shares the single memory port between port 0 (CPU load/store stage) and port 1 (DMA/program-loader). For each request it latches the command, drives one memory access cycle, registers read data and returns a one-cycle acknowledge. It sits between the requesters and the memory; neither requester touches the memory signals directly.

## Interface
Parameters:
- `ADDR_W`, 16: address width, byte address; the memory decodes bits [8:1].
- `DATA_W`, 16: data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  request; held high with a stable command until ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_W  access address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W  registered read data; valid while ack is high and held afterwards.
- `mem_access_addr`  out  ADDR_W  to the memory.
- `mem_write_data`  out  DATA_W  to the memory.
- `mem_write_en`  out  1  to the memory.
- `mem_read`  out  1  to the memory.
- `mem_read_data`  in  DATA_W  from the memory (combinational read).
- `busy`  out  1  high in ACCESS and DONE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req` is high, pick a winner, latch its `we`, `addr` and `wdata` plus the winner ID, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive the latched command to the memory for exactly one cycle, then go to DONE.
  - DONE: pulse the winner's ack, update last-grant, then go to IDLE.
- Memory outputs in ACCESS:
  - `mem_write_en` = latched `we`; `mem_read` = ~latched `we`.
  - `mem_access_addr` = latched addr; `mem_write_data` = latched wdata.
- Memory outputs in every other state: all four are 0.
- Read: `mem_read_data` is captured into the winner's `rdata` register on the edge that ends ACCESS.
  - The other port's `rdata` is unchanged.
  - A write never changes either `rdata`.
- The write is committed by the memory on the edge that ends ACCESS.
- Arbitration happens only in IDLE. A request arriving in ACCESS or DONE waits.
- A single requesting port always wins.
- Both ports requesting:
  - Macro defined: the port not granted last wins (round-robin).
  - Macro undefined: port 0 always wins.
- Last-grant resets to port 1, so port 0 wins the first tie.
- Requester protocol: a requester that keeps `req` high after its ack cycle is treated as issuing a new transaction, sampled in the following IDLE cycle.
- Changing the command while `req` is high and before ack is illegal; the arbiter uses the value latched in IDLE.

## Timing
- Reset (`rst_n` low, asynchronous), immediately:
  - FSM = IDLE, last-grant = 1.
  - `p0_ack`, `p1_ack`, `busy`, `mem_write_en`, `mem_read` = 0.
  - `mem_access_addr`, `mem_write_data`, `p0_rdata`, `p1_rdata` = 0.
- Reset during ACCESS: `mem_write_en` drops at once, no write occurs, and no ack is issued.
- Latency: `req` sampled on edge E0 (IDLE) → ACCESS in cycle E0..E1 → ack high in cycle E1..E2 (DONE) → IDLE from E2.
- Throughput: one transaction per 3 cycles. A port held high continuously is served every 3 cycles when uncontested.
- Round-robin with both ports held high: grants alternate 0,1,0,1…, one ack every 3 cycles.
- The address is passed through unmodified. Out-of-range bits are ignored by the memory; the arbiter does not flag them.

## Configuration
- `DATA_MEM_ARB_RR_EN`:
  - Defined: round-robin tie-break using the last-grant register.
  - Undefined: fixed priority, port 0 over port 1. The last-grant register is still kept and reset, but it is not used for the decision.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle → all outputs 0 immediately; after release, `busy`=0 and FSM idle.
- Write then read on port 0:
  - p0 writes 0xBEEF to addr 0x0010 → `mem_write_en`=1 for exactly one cycle, `p0_ack` two cycles after sampling.
  - p0 then reads 0x0010 → `p0_rdata`=0xBEEF with `p0_ack`; `p1_rdata` unchanged.
- Contention with macro defined: both ports hold reads of addrs 0x0002/0x0004 (preloaded 0x1111/0x2222) → acks ordered p0, p1, p0, p1 at 3-cycle spacing with correct data.
- Contention with macro undefined: same stimulus → only `p0_ack` pulses while `p0_req` is held; p1 is served within 3 cycles of p0 dropping `req`.
- Reset in ACCESS: p1 writes 0x1234 to 0x0020 and `rst_n` is pulsed low during ACCESS → no ack; a later read of 0x0020 returns the prior value (0x0000).
- Late request: `p1_req` rises during p0's ACCESS → p1 is granted in the IDLE cycle after p0's ack; `p1_ack` arrives 3 cycles later.
